// File: rtl/insn_encode_loader_pkg.sv
// Shared definitions for the 8-puzzle CPU program loader.
//   - instruction format classes (in_fmt encodings)
//   - loader FSM state constants
//   - bit positions of each field inside the 16-bit instruction word
//   - imm_width(): how many immediate bits a format can carry
package insn_encode_loader_pkg;

  // Field layout classes
  localparam logic [2:0] F_BR   = 3'd0;
  localparam logic [2:0] F_RR   = 3'd1;
  localparam logic [2:0] F_CMP  = 3'd2;
  localparam logic [2:0] F_CHK  = 3'd3;
  localparam logic [2:0] F_CHK4 = 3'd4;
  localparam logic [2:0] F_ONE  = 3'd5;
  localparam logic [2:0] F_ST   = 3'd6;
  localparam logic [2:0] F_LI   = 3'd7;

  // Loader FSM states
  typedef logic [1:0] state_t;
  localparam state_t StIdle  = 2'd0;
  localparam state_t StLoad  = 2'd1;
  localparam state_t StDrain = 2'd2;
  localparam state_t StDone  = 2'd3;

  // Field LSB positions in the instruction word
  localparam int unsigned OP_LSB        = 11;  // alu_op, 5 bits, all formats
  localparam int unsigned BR_IMM_LSB    = 0;   // 8 bits
  localparam int unsigned RR_DST_LSB    = 7;
  localparam int unsigned RR_SRC1_LSB   = 3;
  localparam int unsigned RR_IMM_LSB    = 0;   // 2 bits
  localparam int unsigned CMP_SRC1_LSB  = 4;
  localparam int unsigned CMP_SRC0_LSB  = 0;
  localparam int unsigned CHK_SRC1_LSB  = 2;
  localparam int unsigned CHK_IMM_LSB   = 0;   // 2 bits
  localparam int unsigned CHK4_SRC1_LSB = 7;
  localparam int unsigned CHK4_IMM_LSB  = 3;   // 4 bits
  localparam int unsigned ONE_SRC1_LSB  = 0;
  localparam int unsigned ST_SRC1_LSB   = 7;
  localparam int unsigned ST_SRC0_LSB   = 3;
  localparam int unsigned LI_DST_LSB    = 7;
  localparam int unsigned LI_IMM_LSB    = 0;   // 7 bits

  // Immediate bits carried by each format. Formats without an immediate field
  // report 0, so any nonzero imm on them counts as out of range.
  function automatic int unsigned imm_width(input logic [2:0] fmt);
    case (fmt)
      F_BR:          return 8;
      F_RR, F_CHK:   return 2;
      F_CHK4:        return 4;
      F_LI:          return 7;
      default:       return 0;
    endcase
  endfunction

endpackage

// File: rtl/insn_encode_loader_pack.sv
// insn_pack: combinational field packer.
// Ports:
//   alu_op    in  5   opcode, always placed in word[15:11]
//   fmt       in  3   field layout class
//   dst       in  4   destination register
//   src1      in  4   source 1 register
//   src0      in  4   source 0 register
//   imm       in  8   immediate / branch target
//   word      out 16  packed instruction (unnamed bits are 0)
//   range_err out 1   imm does not fit its field, or branch target >= DEPTH
module insn_pack
  import insn_encode_loader_pkg::*;
#(
  parameter int unsigned DEPTH = 64
) (
  input  logic [4:0]  alu_op,
  input  logic [2:0]  fmt,
  input  logic [3:0]  dst,
  input  logic [3:0]  src1,
  input  logic [3:0]  src0,
  input  logic [7:0]  imm,
  output logic [15:0] word,
  output logic        range_err
);

  always_comb begin
    word = '0;
    word[OP_LSB +: 5] = alu_op;
    case (fmt)
      F_BR: begin
        word[BR_IMM_LSB +: 8] = imm;
      end
      F_RR: begin
        word[RR_DST_LSB +: 4]  = dst;
        word[RR_SRC1_LSB +: 4] = src1;
        word[RR_IMM_LSB +: 2]  = imm[1:0];
      end
      F_CMP: begin
        word[CMP_SRC1_LSB +: 4] = src1;
        word[CMP_SRC0_LSB +: 4] = src0;
      end
      F_CHK: begin
        word[CHK_SRC1_LSB +: 4] = src1;
        word[CHK_IMM_LSB +: 2]  = imm[1:0];
      end
      F_CHK4: begin
        word[CHK4_SRC1_LSB +: 4] = src1;
        word[CHK4_IMM_LSB +: 4]  = imm[3:0];
      end
      F_ONE: begin
        word[ONE_SRC1_LSB +: 4] = src1;
      end
      F_ST: begin
        word[ST_SRC1_LSB +: 4] = src1;
        word[ST_SRC0_LSB +: 4] = src0;
      end
      F_LI: begin
        word[LI_DST_LSB +: 4] = dst;
        word[LI_IMM_LSB +: 7] = imm[6:0];
      end
      default: ;
    endcase
  end

  // Any bit above the field width is lost; branch targets must also land in memory.
  assign range_err = ((imm >> imm_width(fmt)) != 8'd0) ||
                     ((fmt == F_BR) && ({24'd0, imm} >= DEPTH));

endmodule

// File: rtl/insn_encode_loader.sv
// insn_encode_loader: streams field tuples into instruction memory while
// holding the CPU in reset.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           begin a load session (honoured in IDLE and DONE)
//   in_valid/ready  tuple handshake; in_ready is high only in LOAD
//   in_last         final tuple of the program
//   in_alu_op..imm  instruction fields
//   imem_we/addr/wdata  registered memory write, one cycle after accept
//   cpu_rst         high except in DONE
//   busy, done      LOAD|DRAIN, DONE
//   word_count      words written this session
//   err_range       sticky immediate/branch range error
//   err_overflow    sticky: memory filled before in_last
// DEPTH must equal 2**ADDR_W.
module insn_encode_loader
  import insn_encode_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [4:0]        in_alu_op,
  input  logic [2:0]        in_fmt,
  input  logic [3:0]        in_dst,
  input  logic [3:0]        in_src1,
  input  logic [3:0]        in_src0,
  input  logic [7:0]        in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_count,
  output logic              err_range,
  output logic              err_overflow
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              rerr_q, rerr_d;
  logic              ovf_q, ovf_d;

  logic [15:0] packed_word;
  logic        pack_err;
  logic        accept;
  logic        last_slot;
  logic        enter_load;

  insn_pack #(
    .DEPTH(DEPTH)
  ) u_pack (
    .alu_op    (in_alu_op),
    .fmt       (in_fmt),
    .dst       (in_dst),
    .src1      (in_src1),
    .src0      (in_src0),
    .imm       (in_imm),
    .word      (packed_word),
    .range_err (pack_err)
  );

  assign accept     = (state_q == StLoad) && in_valid;
  assign last_slot  = (addr_q == ADDR_W'(DEPTH - 1));
  assign enter_load = start && ((state_q == StIdle) || (state_q == StDone));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    we_d    = accept;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    rerr_d  = rerr_q;
    ovf_d   = ovf_q;

    case (state_q)
      StIdle:  if (start) state_d = StLoad;
      StLoad:  if (accept && (in_last || last_slot)) state_d = StDrain;
      StDrain: state_d = StDone;
      StDone:  if (start) state_d = StLoad;
      default: state_d = StIdle;
    endcase

    if (enter_load) begin
      addr_d  = '0;
      count_d = '0;
      rerr_d  = 1'b0;
      ovf_d   = 1'b0;
    end

    // Count advances on the accept edge so it rises together with imem_we.
    if (accept) begin
      waddr_d = addr_q;
      wdata_d = packed_word;
      addr_d  = addr_q + ADDR_W'(1);
      count_d = count_q + (ADDR_W+1)'(1);
      if (pack_err) rerr_d = 1'b1;
      if (last_slot && !in_last) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      count_q <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      rerr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      rerr_q  <= rerr_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready     = (state_q == StLoad);
  assign busy         = (state_q == StLoad) || (state_q == StDrain);
  assign done         = (state_q == StDone);
  assign cpu_rst      = (state_q != StDone);
  assign imem_we      = we_q;
  assign imem_addr    = waddr_q;
  assign imem_wdata   = wdata_q;
  assign word_count   = count_q;
  assign err_range    = rerr_q;
  assign err_overflow = ovf_q;

endmodule

// File: tb/tb_insn_encode_loader.sv
// Self-checking bench for insn_encode_loader: table-driven programs from the
// test plan plus random programs checked against an arithmetic encoding model.
module tb_insn_encode_loader;
  import insn_encode_loader_pkg::*;

  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;

  typedef struct {
    logic [2:0]  fmt;
    logic [4:0]  alu;
    logic [3:0]  dst;
    logic [3:0]  src1;
    logic [3:0]  src0;
    logic [7:0]  imm;
    logic        last;
    logic [15:0] word;
    logic        rerr;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst, start, in_valid, in_ready, in_last;
  logic [4:0]        in_alu_op;
  logic [2:0]        in_fmt;
  logic [3:0]        in_dst, in_src1, in_src0;
  logic [7:0]        in_imm;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_wdata;
  logic              cpu_rst, busy, done;
  logic [ADDR_W:0]   word_count;
  logic              err_range, err_overflow;

  always #5 clk = ~clk;

  insn_encode_loader #(
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_last     (in_last),
    .in_alu_op   (in_alu_op),
    .in_fmt      (in_fmt),
    .in_dst      (in_dst),
    .in_src1     (in_src1),
    .in_src0     (in_src0),
    .in_imm      (in_imm),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .cpu_rst     (cpu_rst),
    .busy        (busy),
    .done        (done),
    .word_count  (word_count),
    .err_range   (err_range),
    .err_overflow(err_overflow)
  );

  int   errors = 0;
  int   checks = 0;
  vec_t prog[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'd0, act}, {31'd0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Largest imm (exclusive) that fits each format.
  function automatic int imm_limit(input logic [2:0] fmt);
    case (fmt)
      F_BR:        return DEPTH;
      F_RR, F_CHK: return 4;
      F_CHK4:      return 16;
      F_LI:        return 128;
      default:     return 1;
    endcase
  endfunction

  // Reference encoder built from place values rather than bit slices.
  function automatic vec_t model_vec(input logic [2:0] fmt, input logic [4:0] alu,
                                     input logic [3:0] dst, input logic [3:0] src1,
                                     input logic [3:0] src0, input logic [7:0] imm,
                                     input logic last);
    vec_t v;
    int   d = int'(dst);
    int   s1 = int'(src1);
    int   s0 = int'(src0);
    int   im = int'(imm);
    int   body;
    case (fmt)
      F_BR:    body = im;
      F_RR:    body = d * 128 + s1 * 8 + im % 4;
      F_CMP:   body = s1 * 16 + s0;
      F_CHK:   body = s1 * 4 + im % 4;
      F_CHK4:  body = s1 * 128 + (im % 16) * 8;
      F_ONE:   body = s1;
      F_ST:    body = s1 * 128 + s0 * 8;
      default: body = d * 128 + im % 128;
    endcase
    v.fmt  = fmt;
    v.alu  = alu;
    v.dst  = dst;
    v.src1 = src1;
    v.src0 = src0;
    v.imm  = imm;
    v.last = last;
    v.word = 16'(int'(alu) * 2048 + body);
    v.rerr = (im >= imm_limit(fmt));
    return v;
  endfunction

  function automatic vec_t mk(input logic [2:0] fmt, input logic [4:0] alu,
                              input logic [3:0] dst, input logic [3:0] src1,
                              input logic [3:0] src0, input logic [7:0] imm,
                              input logic last, input logic [15:0] word, input logic rerr);
    vec_t v;
    v.fmt  = fmt;
    v.alu  = alu;
    v.dst  = dst;
    v.src1 = src1;
    v.src0 = src0;
    v.imm  = imm;
    v.last = last;
    v.word = word;
    v.rerr = rerr;
    return v;
  endfunction

  function automatic vec_t rand_vec(input logic last);
    logic [2:0] f = 3'($urandom_range(0, 7));
    logic [7:0] im;
    if ($urandom_range(0, 7) == 0) im = 8'($urandom);
    else im = 8'($urandom_range(0, 32'(imm_limit(f) - 1)));
    return model_vec(f, 5'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), im, last);
  endfunction

  task automatic drive(input vec_t v);
    in_fmt    = v.fmt;
    in_alu_op = v.alu;
    in_dst    = v.dst;
    in_src1   = v.src1;
    in_src0   = v.src0;
    in_imm    = v.imm;
    in_last   = v.last;
  endtask

  // Load prog[] as one session, idle gaps with probability gap_pct%.
  task automatic run_session(input int gap_pct, input string tag);
    int   i = 0;
    int   idle = 0;
    int   n = prog.size();
    logic acc;
    logic exp_rerr = 1'b0;
    logic exp_ovf;

    start    = 1'b1;
    in_valid = 1'b0;
    tick();
    start = 1'b0;
    chk1({tag, ".load_busy"}, busy, 1'b1);
    chk1({tag, ".load_ready"}, in_ready, 1'b1);
    chk1({tag, ".load_cpu_rst"}, cpu_rst, 1'b1);
    chk({tag, ".count_clear"}, 32'(word_count), 32'd0);
    chk1({tag, ".rerr_clear"}, err_range, 1'b0);
    chk1({tag, ".ovf_clear"}, err_overflow, 1'b0);

    while (i < n) begin
      acc      = (idle >= 3) || ($urandom_range(0, 99) >= 32'(gap_pct));
      in_valid = acc;
      start    = ($urandom_range(0, 3) == 0);  // must be ignored in LOAD
      if (acc) drive(prog[i]);
      else drive(rand_vec(1'($urandom)));
      tick();
      if (acc) begin
        exp_rerr = exp_rerr | prog[i].rerr;
        chk1({tag, ".we"}, imem_we, 1'b1);
        chk({tag, ".addr"}, 32'(imem_addr), 32'(i));
        chk({tag, ".data"}, 32'(imem_wdata), 32'(prog[i].word));
        i++;
        idle = 0;
      end else begin
        chk1({tag, ".no_we"}, imem_we, 1'b0);
        idle++;
      end
      chk({tag, ".count"}, 32'(word_count), 32'(i));
      chk1({tag, ".rerr"}, err_range, exp_rerr);
      if (acc && (prog[i-1].last || i == DEPTH)) break;
    end
    exp_ovf = (i == DEPTH) && !prog[i-1].last;

    // DRAIN: start and in_valid must both be ignored
    chk1({tag, ".drain_ready"}, in_ready, 1'b0);
    chk1({tag, ".drain_busy"}, busy, 1'b1);
    chk1({tag, ".drain_done"}, done, 1'b0);
    chk1({tag, ".drain_cpu_rst"}, cpu_rst, 1'b1);
    chk1({tag, ".ovf"}, err_overflow, exp_ovf);
    start    = 1'b1;
    in_valid = 1'b1;
    drive(rand_vec(1'b0));
    tick();
    chk1({tag, ".done"}, done, 1'b1);
    chk1({tag, ".done_cpu_rst"}, cpu_rst, 1'b0);
    chk1({tag, ".done_busy"}, busy, 1'b0);
    chk1({tag, ".drain_no_we"}, imem_we, 1'b0);
    chk({tag, ".done_count"}, 32'(word_count), 32'(i));
    chk1({tag, ".done_rerr"}, err_range, exp_rerr);
    chk1({tag, ".done_ovf"}, err_overflow, exp_ovf);

    // DONE: in_valid must not write
    start = 1'b0;
    tick();
    chk1({tag, ".done_no_we"}, imem_we, 1'b0);
    chk1({tag, ".done_hold"}, done, 1'b1);
    in_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    drive(mk(3'd0, 5'd0, 4'd0, 4'd0, 4'd0, 8'd0, 1'b0, 16'd0, 1'b0));
    tick();
    tick();
    chk1("rst.cpu_rst", cpu_rst, 1'b1);
    chk1("rst.in_ready", in_ready, 1'b0);
    chk1("rst.we", imem_we, 1'b0);
    chk("rst.addr", 32'(imem_addr), 32'd0);
    chk("rst.wdata", 32'(imem_wdata), 32'd0);
    chk1("rst.busy", busy, 1'b0);
    chk1("rst.done", done, 1'b0);
    chk("rst.count", 32'(word_count), 32'd0);
    chk1("rst.rerr", err_range, 1'b0);
    chk1("rst.ovf", err_overflow, 1'b0);

    rst      = 1'b0;
    in_valid = 1'b1;
    tick();
    chk1("idle.no_we", imem_we, 1'b0);
    chk1("idle.busy", busy, 1'b0);
    in_valid = 1'b0;

    prog.delete();
    prog.push_back(mk(F_LI, 5'b10110, 4'd3, 4'd0, 4'd0, 8'h25, 1'b1, 16'hB1A5, 1'b0));
    run_session(0, "single");

    prog.delete();
    prog.push_back(mk(F_CMP,  5'b01000, 4'd0, 4'd7, 4'd9, 8'h00, 1'b0, 16'h4079, 1'b0));
    prog.push_back(mk(F_BR,   5'b00001, 4'd0, 4'd0, 4'd0, 8'h2A, 1'b0, 16'h082A, 1'b0));
    prog.push_back(mk(F_ST,   5'b11000, 4'd0, 4'd5, 4'd2, 8'h00, 1'b0, 16'hC290, 1'b0));
    prog.push_back(mk(F_CHK4, 5'b00110, 4'd0, 4'd4, 4'd0, 8'h0B, 1'b0, 16'h3258, 1'b0));
    prog.push_back(mk(F_CHK,  5'b00101, 4'd0, 4'hC, 4'd0, 8'h02, 1'b1, 16'h2832, 1'b0));
    run_session(0, "b2b");

    prog.delete();
    prog.push_back(mk(F_BR, 5'b00001, 4'd0, 4'd0, 4'd0, 8'h50, 1'b0, 16'h0850, 1'b1));
    prog.push_back(mk(F_LI, 5'b10110, 4'd3, 4'd0, 4'd0, 8'h80, 1'b1, 16'hB180, 1'b1));
    run_session(0, "range");

    prog.delete();
    for (int k = 0; k < DEPTH; k++) prog.push_back(rand_vec(1'b0));
    run_session(0, "ovf");

    // Exactly DEPTH words ending with last: full memory, no overflow
    prog.delete();
    for (int k = 0; k < DEPTH; k++) prog.push_back(rand_vec(k == DEPTH - 1));
    run_session(20, "full");

    for (int s = 0; s < 6; s++) begin
      prog.delete();
      n = int'($urandom_range(1, 40));
      for (int k = 0; k < n; k++) prog.push_back(rand_vec(k == n - 1));
      run_session(30, "rand");
    end

    // Reset in the middle of a load drops the pending write
    start = 1'b1;
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    drive(rand_vec(1'b0));
    tick();
    chk1("abort.first_we", imem_we, 1'b1);
    drive(rand_vec(1'b0));
    rst = 1'b1;
    tick();
    chk1("abort.no_we", imem_we, 1'b0);
    chk1("abort.busy", busy, 1'b0);
    chk1("abort.cpu_rst", cpu_rst, 1'b1);
    chk1("abort.ready", in_ready, 1'b0);
    chk("abort.count", 32'(word_count), 32'd0);
    rst = 1'b0;
    tick();
    chk1("abort.idle_no_we", imem_we, 1'b0);
    chk1("abort.idle_busy", busy, 1'b0);
    in_valid = 1'b0;

    prog.delete();
    prog.push_back(rand_vec(1'b0));
    prog.push_back(rand_vec(1'b1));
    run_session(0, "after_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/insn_encode_loader.md
Name: insn_encode_loader

Overview:
- Program loader for the 8-puzzle CPU: the encoding end of the 16-bit instruction format that the CPU decoder consumes.
- A host or testbench streams instruction field tuples over a valid/ready handshake; the block packs each tuple into a 16-bit word and writes it sequentially into instruction memory.
- The CPU is held in reset until the program is fully loaded.

Parameters:
- ADDR_W, 6, instruction memory address width (matches the 6-bit PC).
- DEPTH, 64, number of instruction words; must equal 2**ADDR_W.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a load session
- in_valid  in  1  field tuple valid
- in_ready  out  1  tuple accepted when in_valid && in_ready
- in_last  in  1  final tuple of the program
- in_alu_op  in  5  placed in word[15:11]
- in_fmt  in  3  field layout class (package constants)
- in_dst  in  4  destination register
- in_src1  in  4  source 1 register
- in_src0  in  4  source 0 register
- in_imm  in  8  immediate or branch target
- imem_we  out  1  instruction memory write strobe
- imem_addr  out  ADDR_W  write address
- imem_wdata  out  16  encoded instruction word
- cpu_rst  out  1  CPU reset hold
- busy  out  1  high in LOAD or DRAIN
- done  out  1  high in DONE
- word_count  out  ADDR_W+1  words written this session
- err_range  out  1  sticky: immediate exceeds its field, or branch target >= DEPTH
- err_overflow  out  1  sticky: memory filled before in_last

Behaviour:
- Clock and reset: clk with a synchronous, active-high reset rst; all state is updated on the rising edge of clk.
- Reset values: state=IDLE, cpu_rst=1, all other outputs 0.
- Encoding: word[15:11]=in_alu_op. All bits not named below are 0.
  - F_BR: [7:0]=imm.
  - F_RR: [10:7]=dst, [6:3]=src1, [1:0]=imm[1:0].
  - F_CMP: [7:4]=src1, [3:0]=src0.
  - F_CHK: [5:2]=src1, [1:0]=imm[1:0].
  - F_CHK4: [10:7]=src1, [6:3]=imm[3:0].
  - F_ONE: [3:0]=src1.
  - F_ST: [10:7]=src1, [6:3]=src0.
  - F_LI: [10:7]=dst, [6:0]=imm[6:0].
- Range check: any nonzero imm bit above the field width sets err_range. For F_BR, imm >= DEPTH also sets err_range. The word is still written, using the truncated value.
- FSM states: IDLE, LOAD, DRAIN, DONE.
  - IDLE: start -> LOAD at the next edge. Entering LOAD clears the address, word_count and both error flags.
  - LOAD: in_ready=1 (the block never back-pressures inside LOAD). A beat accepted in cycle k gives imem_we=1 in cycle k+1, with registered imem_addr/imem_wdata. Throughput is 1 word/cycle; the address increments after each accept.
  - LOAD exit: an accept with in_last, or an accept at address DEPTH-1, moves to DRAIN. If the DEPTH-1 accept lacks in_last, err_overflow is set.
  - DRAIN: in_ready=0. The final write completes. Next state is DONE.
  - DONE: cpu_rst=0, done=1, in_ready=0. start -> LOAD (cpu_rst=1 again in the same edge).
- cpu_rst is 1 in IDLE, LOAD and DRAIN.
- start is ignored in LOAD and DRAIN.
- in_valid outside LOAD is ignored, and no write occurs.
- word_count increments in the same cycle as each imem_we.
- rst asserted mid-load aborts the session: state returns to IDLE, the pending write is dropped, and memory contents are undefined.
- No address wrap: address DEPTH-1 is the last word written.

Decomposition:
- Shared package holds:
  - format constants F_BR=0, F_RR=1, F_CMP=2, F_CHK=3, F_CHK4=4, F_ONE=5, F_ST=6, F_LI=7;
  - the state enum;
  - field bit positions per format.
- One combinational sub-module, insn_pack (fields + fmt -> 16-bit word + range_err), keeps the layout table separate from the FSM and handshake register.

Test Plan:
- Reset, start, single beat F_LI alu_op=10110 dst=3 imm=0x25 last=1 -> imem_we one cycle later, addr 0, data 0xB1A5. Two cycles after that: done=1, cpu_rst=0, word_count=1.
- Back-to-back beats every cycle: F_CMP 01000 src1=7 src0=9; F_BR 00001 imm=0x2A; F_ST 11000 src1=5 src0=2; F_CHK4 00110 src1=4 imm=0xB; F_CHK 00101 src1=0xC imm=2 last -> consecutive writes 0x4079, 0x082A, 0xC290, 0x3258, 0x2832 at addrs 0..4; no errors.
- Range errors: F_BR imm=0x50 sets err_range and writes 0x0850. F_LI with imm=0x80 also sets err_range and writes imm bits as 0.
- Overflow: 64 beats without last -> writes addrs 0..63. After the 64th accept, in_ready drops; err_overflow=1, done=1.
- Ignored inputs: start during LOAD is ignored; in_valid in IDLE and in DONE produces no write.
- Restart and reset:
  - start in DONE reloads from addr 0 with errors cleared.
  - rst mid-LOAD returns to IDLE with cpu_rst=1 and no write in the following cycle.
